lif_scheduler: RTL and testbench

LIF_SCHEDULER -- requirements
Module: lif_scheduler

---
 rtl/lif_pkg.sv | 18 +
 rtl/lif_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_lif_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared widths, FSM encodings and LIF constants for the LIF scheduler
package lif_pkg;

   localparam int FP_W             = 32;
   localparam int REF_W            = 2;
   localparam int REFRACTORY_RESET = 2;

   typedef enum logic [6:0] {
      S_IDLE     = 7'b000_0001,
      S_READ     = 7'b000_0010,
      S_LATCH    = 7'b000_0100,
      S_FIRE     = 7'b000_1000,
      S_WAIT_LIF = 7'b001_0000,
      S_WRITE    = 7'b010_0000,
      S_DONE     = 7'b100_0000
   } state_e;

endpackage

// File: rtl/lif_scheduler.sv
// rtl/lif_scheduler.sv - walks every neuron once per timestep: read state, run the LIF datapath, write back
module lif_scheduler
   import lif_pkg::*;
#(
   parameter int NUM_NEURONS = 16,
   parameter int ADDR_W      = 4,
   parameter int WDT_MAX     = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_step,
   output logic              busy,
   output logic              step_done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [FP_W-1:0]   mem_rd_bias,
   input  logic [FP_W-1:0]   mem_rd_enc,
   input  logic [FP_W-1:0]   mem_rd_volt,
   input  logic [REF_W-1:0]  mem_rd_ref,
   output logic              mem_wr_en,
   output logic [FP_W-1:0]   mem_wr_volt,
   output logic [REF_W-1:0]  mem_wr_ref,
   output logic              start_lif,
   output logic [FP_W-1:0]   bias,
   output logic [FP_W-1:0]   encoders,
   output logic [FP_W-1:0]   voltage_old,
   output logic [REF_W-1:0]  refractory_time_old,
   input  logic              spike_valid,
   input  logic              spike_output,
   input  logic [REF_W-1:0]  refractory_time_new,
   input  logic [FP_W-1:0]   voltage_new,
   output logic              spike_evt_valid,
   output logic [ADDR_W-1:0] spike_evt_id,
   output logic [ADDR_W:0]   spike_count,
   output logic              wdt_err
);

   localparam int                CNT_W     = $clog2(WDT_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);
   localparam logic [CNT_W-1:0]  WDT_LAST  = CNT_W'(WDT_MAX - 1);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W:0]    spike_cnt_q, spike_cnt_d;
   logic               wdt_err_q, wdt_err_d;
   logic [CNT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
   logic               timeout_q, timeout_d;
   logic [FP_W-1:0]    bias_q, bias_d;
   logic [FP_W-1:0]    enc_q, enc_d;
   logic [FP_W-1:0]    volt_q, volt_d;
   logic [REF_W-1:0]   ref_q, ref_d;
   logic [FP_W-1:0]    vnew_q, vnew_d;
   logic [REF_W-1:0]   rnew_q, rnew_d;
   logic               spk_q, spk_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         spike_cnt_q <= '0;
         wdt_err_q   <= 1'b0;
         wdt_cnt_q   <= '0;
         timeout_q   <= 1'b0;
         bias_q      <= '0;
         enc_q       <= '0;
         volt_q      <= '0;
         ref_q       <= '0;
         vnew_q      <= '0;
         rnew_q      <= '0;
         spk_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         spike_cnt_q <= spike_cnt_d;
         wdt_err_q   <= wdt_err_d;
         wdt_cnt_q   <= wdt_cnt_d;
         timeout_q   <= timeout_d;
         bias_q      <= bias_d;
         enc_q       <= enc_d;
         volt_q      <= volt_d;
         ref_q       <= ref_d;
         vnew_q      <= vnew_d;
         rnew_q      <= rnew_d;
         spk_q       <= spk_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      spike_cnt_d     = spike_cnt_q;
      wdt_err_d       = wdt_err_q;
      wdt_cnt_d       = wdt_cnt_q;
      timeout_d       = timeout_q;
      bias_d          = bias_q;
      enc_d           = enc_q;
      volt_d          = volt_q;
      ref_d           = ref_q;
      vnew_d          = vnew_q;
      rnew_d          = rnew_q;
      spk_d           = spk_q;
      mem_rd_en       = 1'b0;
      start_lif       = 1'b0;
      mem_wr_en       = 1'b0;
      spike_evt_valid = 1'b0;
      step_done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_step) begin
               state_d     = S_READ;
               addr_d      = '0;
               spike_cnt_d = '0;
               wdt_err_d   = 1'b0;
            end
         end
         S_READ: begin
            mem_rd_en = 1'b1;
            state_d   = S_LATCH;
         end
         S_LATCH: begin
            bias_d  = mem_rd_bias;
            enc_d   = mem_rd_enc;
            volt_d  = mem_rd_volt;
            ref_d   = mem_rd_ref;
            state_d = S_FIRE;
         end
         S_FIRE: begin
            start_lif = 1'b1;
            wdt_cnt_d = '0;
            timeout_d = 1'b0;
            state_d   = S_WAIT_LIF;
         end
         S_WAIT_LIF: begin
            if (spike_valid) begin
               vnew_d  = voltage_new;
               rnew_d  = refractory_time_new;
               spk_d   = spike_output;
               state_d = S_WRITE;
            end else if (wdt_cnt_q == WDT_LAST) begin
               // The stalled neuron keeps its stored state; the rest of the step still runs.
               timeout_d = 1'b1;
               wdt_err_d = 1'b1;
               spk_d     = 1'b0;
               state_d   = S_WRITE;
            end else begin
               wdt_cnt_d = wdt_cnt_q + CNT_W'(1);
            end
         end
         S_WRITE: begin
            if (!timeout_q) begin
               mem_wr_en = 1'b1;
               if (spk_q) begin
                  spike_evt_valid = 1'b1;
                  spike_cnt_d     = spike_cnt_q + (ADDR_W + 1)'(1);
               end
            end
            if (addr_q == LAST_ADDR) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_READ;
            end
         end
         S_DONE: begin
            step_done = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy                = (state_q != S_IDLE);
   assign mem_addr            = addr_q;
   assign spike_evt_id        = spike_evt_valid ? addr_q : '0;
   assign spike_count         = spike_cnt_q;
   assign wdt_err             = wdt_err_q;
   assign bias                = bias_q;
   assign encoders            = enc_q;
   assign voltage_old         = volt_q;
   assign refractory_time_old = ref_q;
   assign mem_wr_volt         = vnew_q;
   assign mem_wr_ref          = rnew_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// tb/tb_lif_scheduler.sv - directed bench with state RAM and 9-cycle LIF models for lif_scheduler
module tb_lif_scheduler;
   import lif_pkg::*;

   localparam int NN      = 4;
   localparam int AW      = 4;
   localparam int WDT     = 15;
   localparam int LIF_LAT = 9;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_step;
   logic            busy, step_done, mem_rd_en, mem_wr_en, start_lif;
   logic [AW-1:0]   mem_addr, spike_evt_id;
   logic [31:0]     mem_rd_bias, mem_rd_enc, mem_rd_volt;
   logic [1:0]      mem_rd_ref, mem_wr_ref, refractory_time_old, refractory_time_new;
   logic [31:0]     mem_wr_volt, bias, encoders, voltage_old, voltage_new;
   logic            spike_valid, spike_output, spike_evt_valid, wdt_err;
   logic [AW:0]     spike_count;

   lif_scheduler #(.NUM_NEURONS(NN), .ADDR_W(AW), .WDT_MAX(WDT)) dut (
      .clk(clk), .rst(rst), .start_step(start_step), .busy(busy), .step_done(step_done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_bias(mem_rd_bias), .mem_rd_enc(mem_rd_enc),
      .mem_rd_volt(mem_rd_volt), .mem_rd_ref(mem_rd_ref), .mem_wr_en(mem_wr_en), .mem_wr_volt(mem_wr_volt),
      .mem_wr_ref(mem_wr_ref), .start_lif(start_lif), .bias(bias), .encoders(encoders),
      .voltage_old(voltage_old), .refractory_time_old(refractory_time_old), .spike_valid(spike_valid),
      .spike_output(spike_output), .refractory_time_new(refractory_time_new), .voltage_new(voltage_new),
      .spike_evt_valid(spike_evt_valid), .spike_evt_id(spike_evt_id), .spike_count(spike_count),
      .wdt_err(wdt_err)
   );

   always #5 clk = ~clk;

   logic [31:0] m_bias [NN], m_enc [NN], m_volt [NN];
   logic [1:0]  m_ref [NN];
   int withhold_addr = -1, spike_addr = -1;
   logic stray_req = 1'b0;

   int checks = 0, errors = 0;
   int cyc = 0, lif_cnt = 0, wr_count = 0, evt_count = 0, done_count = 0;
   int op_bad = 0, opnd_bad = 0, lif_wide = 0, bad_busy = 0;
   int last_rd_cyc = 0, lat0 = 0, fire1_cyc = 0, wdt_cyc = 0;
   int wr_addr [64], wr_ref [64];
   logic [31:0] wr_volt [64];
   logic [AW-1:0] evt_id = '0;
   logic [97:0] op_snap;
   logic op_watch = 1'b0, prev_start = 1'b0, prev_wdt = 1'b0;
   logic lif_spike;
   logic [31:0] lif_volt;
   logic [1:0] lif_ref;

   // RAM and LIF models plus protocol monitors, all evaluated on the falling edge.
   always @(negedge clk) begin
      cyc++;
      spike_valid = 1'b0; spike_output = 1'b0; voltage_new = '0; refractory_time_new = '0;
      if (!rst) begin
         lif_cnt = 0; op_watch = 1'b0; prev_start = 1'b0; prev_wdt = 1'b0;
      end else begin
         if (stray_req) begin
            spike_valid = 1'b1; spike_output = 1'b1; voltage_new = 32'hDEAD_BEEF; refractory_time_new = 2'd3;
         end
         if (lif_cnt != 0) begin
            lif_cnt--;
            if (lif_cnt == 0) begin
               spike_valid = 1'b1; spike_output = lif_spike; voltage_new = lif_volt; refractory_time_new = lif_ref;
            end
         end
         if (mem_rd_en) begin
            mem_rd_bias = m_bias[mem_addr]; mem_rd_enc = m_enc[mem_addr];
            mem_rd_volt = m_volt[mem_addr]; mem_rd_ref = m_ref[mem_addr];
            last_rd_cyc = cyc; op_watch = 1'b0;
         end
         if (op_watch && {bias, encoders, voltage_old, refractory_time_old} != op_snap) op_bad++;
         if (start_lif) begin
            if (prev_start) lif_wide++;
            op_snap = {bias, encoders, voltage_old, refractory_time_old};
            op_watch = 1'b1;
            if (bias != m_bias[mem_addr] || encoders != m_enc[mem_addr] ||
                voltage_old != m_volt[mem_addr] || refractory_time_old != m_ref[mem_addr]) opnd_bad++;
            if (mem_addr == AW'(1)) fire1_cyc = cyc;
            if (int'(mem_addr) != withhold_addr) begin
               lif_cnt   = LIF_LAT;
               lif_spike = (int'(mem_addr) == spike_addr);
               lif_volt  = voltage_old + bias;
               lif_ref   = lif_spike ? 2'(REFRACTORY_RESET) :
                           (refractory_time_old != 0 ? refractory_time_old - 2'd1 : 2'd0);
            end
         end
         prev_start = start_lif;
         if (spike_evt_valid) begin evt_count++; evt_id = spike_evt_id; end
         if (step_done) done_count++;
         if ((mem_rd_en || start_lif || mem_wr_en || step_done) && !busy) bad_busy++;
         if (wdt_err && !prev_wdt) wdt_cyc = cyc;
         prev_wdt = wdt_err;
      end
      if (mem_wr_en) begin
         if (wr_count < 64) begin
            wr_addr[wr_count] = int'(mem_addr); wr_volt[wr_count] = mem_wr_volt; wr_ref[wr_count] = int'(mem_wr_ref);
         end
         if (mem_addr == '0) lat0 = cyc - last_rd_cyc;
         wr_count++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start_step = 1'b1;
      @(posedge clk); #1 start_step = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      for (int i = 0; i < 500 && done_count == d0; i++) tick(1);
      check(tag, 64'(done_count - d0 != 0), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {busy, step_done, mem_rd_en, mem_wr_en, start_lif, spike_evt_valid, wdt_err}, 0);
      check({tag, "_addr"}, {mem_addr, spike_evt_id, spike_count}, 0);
      check({tag, "_opnd"}, {bias, encoders}, 0);
      check({tag, "_opnd2"}, {voltage_old, refractory_time_old}, 0);
      check({tag, "_wr"}, {mem_wr_volt, mem_wr_ref}, 0);
   endtask

   task automatic load_ram(input logic [31:0] vstep, input logic [1:0] r0, input logic [1:0] r1);
      for (int i = 0; i < NN; i++) begin
         m_bias[i] = 32'h3F80_0000; m_enc[i] = '0; m_volt[i] = vstep * 32'(i); m_ref[i] = '0;
      end
      m_ref[0] = r0; m_ref[1] = r1;
   endtask

   int w0, d0, e0;

   initial begin
      rst = 1'b0; start_step = 1'b0;
      load_ram(32'd0, 2'd0, 2'd0);
      tick(3);
      check_all_zero("reset");
      @(posedge clk); #1 rst = 1'b1;
      tick(2);

      // basic step: no spikes, every neuron written in order
      w0 = wr_count; d0 = done_count; e0 = evt_count;
      pulse_start();
      check("busy_after_start", busy, 1);
      wait_done(d0, "t1_done_seen");
      tick(2);
      check("t1_wr_count", wr_count - w0, NN);
      for (int i = 0; i < NN; i++) begin
         check($sformatf("t1_wr_addr%0d", i), wr_addr[w0 + i], i);
         check($sformatf("t1_wr_volt%0d", i), wr_volt[w0 + i], 32'h3F80_0000);
      end
      check("t1_spike_count", spike_count, 0);
      check("t1_evt_count", evt_count - e0, 0);
      check("t1_done_count", done_count - d0, 1);
      check("t1_latency", lat0, 4 + LIF_LAT - 1);
      check("t1_busy_idle", busy, 0);
      check("t1_wdt_err", wdt_err, 0);

      // neuron 2 spikes; stored refractory counts decay on the others
      load_ram(32'd1, 2'd2, 2'd1);
      spike_addr = 2;
      w0 = wr_count; d0 = done_count; e0 = evt_count;
      pulse_start();
      wait_done(d0, "t2_done_seen");
      tick(2);
      check("t2_evt_count", evt_count - e0, 1);
      check("t2_evt_id", evt_id, 2);
      check("t2_spike_count", spike_count, 1);
      check("t2_ref_a0", wr_ref[w0 + 0], 1);
      check("t2_ref_a1", wr_ref[w0 + 1], 0);
      check("t2_ref_a2", {wr_addr[w0 + 2], wr_ref[w0 + 2]}, {32'd2, 32'd2});
      check("t2_volt_a3", wr_volt[w0 + 3], 32'h3F80_0003);
      spike_addr = -1;
      // stray spike_valid while idle must not write or count
      w0 = wr_count; e0 = evt_count;
      @(posedge clk); #1 stray_req = 1'b1;
      tick(1); stray_req = 1'b0;
      tick(3);
      check("stray_wr", wr_count - w0, 0);
      check("stray_cnt", {spike_count, 32'(evt_count - e0)}, {5'd1, 32'd0});

      // second start while busy is ignored
      load_ram(32'd0, 2'd0, 2'd0);
      w0 = wr_count; d0 = done_count;
      pulse_start();
      tick(5);
      pulse_start();
      wait_done(d0, "t3_done_seen");
      tick(30);
      check("t3_wr_count", wr_count - w0, NN);
      check("t3_done_count", done_count - d0, 1);

      // neuron 1 never answers: watchdog fires, neuron 1 skipped
      withhold_addr = 1;
      w0 = wr_count; d0 = done_count;
      pulse_start();
      wait_done(d0, "t4_done_seen");
      tick(2);
      check("t4_wdt_err", wdt_err, 1);
      check("t4_wdt_window", 64'((wdt_cyc - fire1_cyc) >= WDT && (wdt_cyc - fire1_cyc) <= WDT + 1), 1);
      check("t4_wr_count", wr_count - w0, NN - 1);
      check("t4_wr_addrs", {wr_addr[w0], wr_addr[w0 + 1], wr_addr[w0 + 2]}, {32'd0, 32'd2, 32'd3});

      // reset while waiting on neuron 1 aborts the step
      w0 = wr_count; d0 = done_count;
      pulse_start();
      for (int i = 0; i < 200 && !(start_lif && mem_addr == AW'(1)); i++) tick(1);
      check("t5_reached_n1", {start_lif, mem_addr}, {1'b1, 4'd1});
      tick(3);
      rst = 1'b0;
      #1 check_all_zero("t5_mid_reset");
      tick(3);
      @(posedge clk); #1 rst = 1'b1;
      tick(40);
      check("t5_wr_count", wr_count - w0, 1);
      check("t5_done_count", done_count - d0, 0);
      withhold_addr = -1;
      w0 = wr_count; d0 = done_count;
      pulse_start();
      wait_done(d0, "t5b_done_seen");
      tick(2);
      check("t5b_wr_count", wr_count - w0, NN);
      check("t5b_first_addr", wr_addr[w0], 0);
      check("t5b_wdt_cleared", wdt_err, 0);

      // protocol monitors over the whole run
      check("start_lif_width", lif_wide, 0);
      check("operand_stable", op_bad, 0);
      check("operand_match", opnd_bad, 0);
      check("busy_cover", bad_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
